ps2_keymatrix: RTL and testbench

//  Consumes completed PS/2 scancode bytes from the PS/2 receive driver.

---
 rtl/ps2_keymatrix.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_keymatrix.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keymatrix.sv
// PS/2 scancode decoder feeding a 10x8 BBC Micro keyboard matrix.
// The VIA scan logic reads the matrix by column/row; F12 is exported as BREAK.
module ps2_keymatrix #(
  parameter logic [7:0] DIP_SWITCHES = 8'h00,
  parameter int unsigned PAUSE_SKIP  = 7
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       i_clk_en,
  input  logic [7:0] i_ps2_byte,
  input  logic       i_ps2_done,
  input  logic [3:0] i_column,
  input  logic [2:0] i_row,
  output logic       o_key_pressed,
  output logic       o_column_act,
  output logic       o_break_key
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BRK     = 3'd1,
    ST_EXT     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } state_t;

  localparam logic [7:0] LP_SKIP = 8'(PAUSE_SKIP);

  state_t      r_state;
  logic [7:0]  r_skip_cnt;
  logic [79:0] r_matrix;
  logic        r_break_key;

  logic        w_event;
  logic        w_ext;
  logic        w_prefix;
  logic [7:0]  w_lookup;
  logic        w_hit;
  logic [6:0]  w_idx;
  logic [7:0]  w_col_bits;
  logic [3:0]  w_dip_off;
  logic        w_key_pressed;

  function automatic logic [7:0] f_key(input logic [3:0] c, input logic [2:0] r);
    return {1'b1, c, r};
  endfunction

  // Entry format {hit, col, row}; bit 8 of the code marks an E0-prefixed key.
  function automatic logic [7:0] f_lookup(input logic [8:0] code);
    case (code)
      9'h012, 9'h059: f_lookup = f_key(4'd0, 3'd0);
      9'h014, 9'h114: f_lookup = f_key(4'd1, 3'd0);
      9'h015: f_lookup = f_key(4'd0, 3'd1);
      9'h026: f_lookup = f_key(4'd1, 3'd1);
      9'h025: f_lookup = f_key(4'd2, 3'd1);
      9'h02E: f_lookup = f_key(4'd3, 3'd1);
      9'h00C: f_lookup = f_key(4'd4, 3'd1);
      9'h03E: f_lookup = f_key(4'd5, 3'd1);
      9'h083: f_lookup = f_key(4'd6, 3'd1);
      9'h04E: f_lookup = f_key(4'd7, 3'd1);
      9'h055: f_lookup = f_key(4'd8, 3'd1);
      9'h16B: f_lookup = f_key(4'd9, 3'd1);
      9'h009: f_lookup = f_key(4'd0, 3'd2);
      9'h01D: f_lookup = f_key(4'd1, 3'd2);
      9'h024: f_lookup = f_key(4'd2, 3'd2);
      9'h02C: f_lookup = f_key(4'd3, 3'd2);
      9'h03D: f_lookup = f_key(4'd4, 3'd2);
      9'h043: f_lookup = f_key(4'd5, 3'd2);
      9'h046: f_lookup = f_key(4'd6, 3'd2);
      9'h045: f_lookup = f_key(4'd7, 3'd2);
      9'h172: f_lookup = f_key(4'd9, 3'd2);
      9'h016: f_lookup = f_key(4'd0, 3'd3);
      9'h01E: f_lookup = f_key(4'd1, 3'd3);
      9'h023: f_lookup = f_key(4'd2, 3'd3);
      9'h02D: f_lookup = f_key(4'd3, 3'd3);
      9'h036: f_lookup = f_key(4'd4, 3'd3);
      9'h03C: f_lookup = f_key(4'd5, 3'd3);
      9'h044: f_lookup = f_key(4'd6, 3'd3);
      9'h04D: f_lookup = f_key(4'd7, 3'd3);
      9'h054: f_lookup = f_key(4'd8, 3'd3);
      9'h175: f_lookup = f_key(4'd9, 3'd3);
      9'h058: f_lookup = f_key(4'd0, 3'd4);
      9'h01C: f_lookup = f_key(4'd1, 3'd4);
      9'h022: f_lookup = f_key(4'd2, 3'd4);
      9'h02B: f_lookup = f_key(4'd3, 3'd4);
      9'h035: f_lookup = f_key(4'd4, 3'd4);
      9'h03B: f_lookup = f_key(4'd5, 3'd4);
      9'h042: f_lookup = f_key(4'd6, 3'd4);
      9'h052: f_lookup = f_key(4'd7, 3'd4);
      9'h05A, 9'h15A: f_lookup = f_key(4'd9, 3'd4);
      9'h01B: f_lookup = f_key(4'd1, 3'd5);
      9'h021: f_lookup = f_key(4'd2, 3'd5);
      9'h034: f_lookup = f_key(4'd3, 3'd5);
      9'h033: f_lookup = f_key(4'd4, 3'd5);
      9'h031: f_lookup = f_key(4'd5, 3'd5);
      9'h04B: f_lookup = f_key(4'd6, 3'd5);
      9'h04C: f_lookup = f_key(4'd7, 3'd5);
      9'h05B: f_lookup = f_key(4'd8, 3'd5);
      9'h066, 9'h171: f_lookup = f_key(4'd9, 3'd5);
      9'h00D: f_lookup = f_key(4'd0, 3'd6);
      9'h01A: f_lookup = f_key(4'd1, 3'd6);
      9'h029: f_lookup = f_key(4'd2, 3'd6);
      9'h02A: f_lookup = f_key(4'd3, 3'd6);
      9'h032: f_lookup = f_key(4'd4, 3'd6);
      9'h03A: f_lookup = f_key(4'd5, 3'd6);
      9'h041: f_lookup = f_key(4'd6, 3'd6);
      9'h049: f_lookup = f_key(4'd7, 3'd6);
      9'h04A: f_lookup = f_key(4'd8, 3'd6);
      9'h169: f_lookup = f_key(4'd9, 3'd6);
      9'h076: f_lookup = f_key(4'd0, 3'd7);
      9'h005: f_lookup = f_key(4'd1, 3'd7);
      9'h006: f_lookup = f_key(4'd2, 3'd7);
      9'h004: f_lookup = f_key(4'd3, 3'd7);
      9'h003: f_lookup = f_key(4'd4, 3'd7);
      9'h00B: f_lookup = f_key(4'd5, 3'd7);
      9'h00A: f_lookup = f_key(4'd6, 3'd7);
      9'h001: f_lookup = f_key(4'd7, 3'd7);
      9'h05D: f_lookup = f_key(4'd8, 3'd7);
      9'h174: f_lookup = f_key(4'd9, 3'd7);
      default: f_lookup = 8'h00;
    endcase
  endfunction

  assign w_event  = i_clk_en & i_ps2_done;
  assign w_ext    = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign w_prefix = (i_ps2_byte == 8'hE0) || (i_ps2_byte == 8'hE1) || (i_ps2_byte == 8'hF0);
  assign w_lookup = f_lookup({w_ext, i_ps2_byte});
  assign w_hit    = w_lookup[7];
  // col*8+row is simply the concatenation {col,row}.
  assign w_idx    = w_lookup[6:0];

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      r_state     <= ST_IDLE;
      r_skip_cnt  <= 8'd0;
      r_matrix    <= 80'd0;
      r_break_key <= 1'b0;
    end else if (w_event) begin
      case (r_state)
        ST_IDLE: begin
          case (i_ps2_byte)
            8'hF0: r_state <= ST_BRK;
            8'hE0: r_state <= ST_EXT;
            8'hE1: begin
              r_state    <= ST_SKIP;
              r_skip_cnt <= LP_SKIP;
            end
            8'hAA: begin
              r_matrix    <= 80'd0;
              r_break_key <= 1'b0;
            end
            8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: r_state <= ST_IDLE;
            8'h07: r_break_key <= 1'b1;
            default: if (w_hit) r_matrix[w_idx] <= 1'b1;
          endcase
        end
        ST_EXT: begin
          if (i_ps2_byte == 8'hF0) begin
            r_state <= ST_EXT_BRK;
          end else begin
            r_state <= ST_IDLE;
            if (w_hit) r_matrix[w_idx] <= 1'b1;
          end
        end
        ST_BRK: begin
          r_state <= ST_IDLE;
          if (!w_prefix) begin
            if (i_ps2_byte == 8'h07) r_break_key <= 1'b0;
            else if (w_hit) r_matrix[w_idx] <= 1'b0;
          end
        end
        ST_EXT_BRK: begin
          r_state <= ST_IDLE;
          if (!w_prefix && w_hit) r_matrix[w_idx] <= 1'b0;
        end
        ST_SKIP: begin
          if (r_skip_cnt <= 8'd1) begin
            r_skip_cnt <= 8'd0;
            r_state    <= ST_IDLE;
          end else begin
            r_skip_cnt <= r_skip_cnt - 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Columns 10..15 select nothing, so both outputs read 0 there.
  always_comb begin
    case (i_column)
      4'd0: w_col_bits = r_matrix[7:0];
      4'd1: w_col_bits = r_matrix[15:8];
      4'd2: w_col_bits = r_matrix[23:16];
      4'd3: w_col_bits = r_matrix[31:24];
      4'd4: w_col_bits = r_matrix[39:32];
      4'd5: w_col_bits = r_matrix[47:40];
      4'd6: w_col_bits = r_matrix[55:48];
      4'd7: w_col_bits = r_matrix[63:56];
      4'd8: w_col_bits = r_matrix[71:64];
      4'd9: w_col_bits = r_matrix[79:72];
      default: w_col_bits = 8'd0;
    endcase
  end

  assign w_dip_off = i_column - 4'd2;

  // Row 0 of columns 2..9 carries the startup links rather than keys.
  always_comb begin
    if ((i_row == 3'd0) && (i_column >= 4'd2) && (i_column <= 4'd9)) begin
      w_key_pressed = DIP_SWITCHES[w_dip_off[2:0]];
    end else begin
      w_key_pressed = w_col_bits[i_row];
    end
  end

  assign o_key_pressed = w_key_pressed;
  assign o_column_act  = |w_col_bits[7:1];
  assign o_break_key   = r_break_key;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Directed bench for ps2_keymatrix: expectations queued with each step, checked once the byte lands.
module tb_ps2_keymatrix;

  logic       clk;
  logic       nRESET;
  logic       i_clk_en;
  logic [7:0] i_ps2_byte;
  logic       i_ps2_done;
  logic [3:0] i_column;
  logic [2:0] i_row;
  logic       o_key_pressed;
  logic       o_column_act;
  logic       o_break_key;

  typedef struct {
    string      tag;
    int         kind;
    logic [3:0] col;
    logic [2:0] row;
    logic       exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  ps2_keymatrix #(.DIP_SWITCHES(8'hA5), .PAUSE_SKIP(7)) dut (
    .clk          (clk),
    .nRESET       (nRESET),
    .i_clk_en     (i_clk_en),
    .i_ps2_byte   (i_ps2_byte),
    .i_ps2_done   (i_ps2_done),
    .i_column     (i_column),
    .i_row        (i_row),
    .o_key_pressed(o_key_pressed),
    .o_column_act (o_column_act),
    .o_break_key  (o_break_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_kp(input string tag, input int c, input int r, input logic e);
    q.push_back('{tag: tag, kind: 0, col: 4'(c), row: 3'(r), exp: e});
  endtask

  task automatic chk_act(input string tag, input int c, input logic e);
    q.push_back('{tag: tag, kind: 1, col: 4'(c), row: 3'd0, exp: e});
  endtask

  task automatic chk_brk(input string tag, input logic e);
    q.push_back('{tag: tag, kind: 2, col: 4'd0, row: 3'd0, exp: e});
  endtask

  // Samples land on even times; clock edges sit on odd multiples of 5.
  task automatic drain();
    exp_t e;
    logic obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      i_column = e.col;
      i_row    = e.row;
      #2;
      case (e.kind)
        0:       obs = o_key_pressed;
        1:       obs = o_column_act;
        default: obs = o_break_key;
      endcase
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input logic en = 1'b1);
    @(negedge clk);
    i_ps2_byte = b;
    i_ps2_done = 1'b1;
    i_clk_en   = en;
    @(negedge clk);
    i_ps2_done = 1'b0;
    i_clk_en   = 1'b1;
    drain();
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRESET = 1'b0;
    @(negedge clk);
    nRESET = 1'b1;
  endtask

  initial begin
    logic [7:0] pause_seq[7];
    logic [7:0] dip;
    pause_seq = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    dip = 8'hA5;

    nRESET = 1'b0; i_clk_en = 1'b1; i_ps2_done = 1'b0; i_ps2_byte = 8'h00;
    i_column = 4'd0; i_row = 3'd0;
    repeat (3) @(negedge clk);
    nRESET = 1'b1;

    chk_kp("rst_a", 1, 4, 1'b0); chk_kp("rst_shift", 0, 0, 1'b0); chk_brk("rst_brk", 1'b0);
    chk_act("rst_act1", 1, 1'b0); chk_act("rst_act9", 9, 1'b0); chk_kp("rst_up", 9, 3, 1'b0);
    drain();

    // Test 1: A make/break, plus a DONE pulse without clock enable
    chk_kp("t1_noen", 1, 4, 1'b0); send(8'h1C, 1'b0);
    chk_kp("t1_make", 1, 4, 1'b1); chk_act("t1_act_on", 1, 1'b1); send(8'h1C);
    chk_kp("t1_f0_hold", 1, 4, 1'b1); send(8'hF0);
    chk_kp("t1_break", 1, 4, 1'b0); chk_act("t1_act_off", 1, 1'b0); send(8'h1C);

    // Test 2: extended cursor keys
    chk_kp("t2_e0_only", 9, 3, 1'b0); send(8'hE0);
    chk_kp("t2_up_make", 9, 3, 1'b1); chk_act("t2_act9_on", 9, 1'b1); send(8'h75);
    send(8'hE0); send(8'hF0);
    chk_kp("t2_up_break", 9, 3, 1'b0); chk_act("t2_act9_off", 9, 1'b0); send(8'h75);
    chk_kp("t2_kp8", 9, 3, 1'b0); send(8'h75);
    send(8'hE0);
    chk_kp("t2_left_make", 9, 1, 1'b1); send(8'h6B);
    send(8'hE0); send(8'hF0);
    chk_kp("t2_left_break", 9, 1, 1'b0); send(8'h6B);

    // Test 3: shift held while A repeats; row 0 never counts as column activity
    chk_kp("t3_shift", 0, 0, 1'b1); chk_act("t3_act0", 0, 1'b0); send(8'h12);
    for (int i = 0; i < 5; i++) begin
      chk_kp($sformatf("t3_rep%0d_a", i), 1, 4, 1'b1);
      chk_kp($sformatf("t3_rep%0d_shift", i), 0, 0, 1'b1);
      send(8'h1C);
    end
    send(8'hF0);
    chk_kp("t3_a_rel", 1, 4, 1'b0); chk_kp("t3_shift_held", 0, 0, 1'b1);
    chk_act("t3_act0_still", 0, 1'b0); send(8'h1C);
    chk_kp("t3_esc", 0, 7, 1'b1); chk_act("t3_act0_esc", 0, 1'b1); send(8'h76);
    send(8'hF0);
    chk_kp("t3_esc_rel", 0, 7, 1'b0); chk_act("t3_act0_esc_rel", 0, 1'b0); send(8'h76);
    chk_kp("t3_rshift", 0, 0, 1'b1); send(8'h59);
    send(8'hF0);
    chk_kp("t3_rshift_rel_shared", 0, 0, 1'b0); send(8'h59);
    send(8'hF0);
    chk_kp("t3_lshift_rel_noop", 0, 0, 1'b0); send(8'h12);
    send(8'hE0);
    chk_kp("t3_rctrl", 1, 0, 1'b1); chk_act("t3_act1_ctrl", 1, 1'b0); send(8'h14);
    send(8'hF0);
    chk_kp("t3_lctrl_rel", 1, 0, 1'b0); send(8'h14);

    // Test 4: Pause sequence swallowed, then SPACE
    send(8'hE1);
    for (int i = 0; i < 7; i++) begin
      chk_kp($sformatf("t4_pause%0d_ctrl", i), 1, 0, 1'b0);
      send(pause_seq[i]);
    end
    chk_kp("t4_space", 2, 6, 1'b1); chk_act("t4_act2", 2, 1'b1); send(8'h29);
    send(8'hE1);
    repeat (6) send(8'h00);
    chk_kp("t4_skip_last", 1, 4, 1'b0); send(8'h1C);
    chk_kp("t4_after_skip", 1, 4, 1'b1); send(8'h1C);
    send(8'hF0);
    chk_kp("t4_a_rel", 1, 4, 1'b0); send(8'h1C);
    send(8'hF0); send(8'hE0);
    chk_kp("t4_discard_up", 9, 3, 1'b0); chk_kp("t4_discard_space", 2, 6, 1'b1); send(8'h75);
    chk_kp("t4_ignore_fa", 2, 6, 1'b1); send(8'hFA);

    // Test 5: BREAK key, self-test clear, reset mid-sequence
    chk_brk("t5_brk_on", 1'b1); send(8'h07);
    send(8'hF0);
    chk_brk("t5_brk_off", 1'b0); send(8'h07);
    chk_brk("t5_brk_on2", 1'b1); send(8'h07);
    chk_kp("t5_a", 1, 4, 1'b1); send(8'h1C);
    chk_kp("t5_space", 2, 6, 1'b1); send(8'h29);
    chk_kp("t5_aa_a", 1, 4, 1'b0); chk_kp("t5_aa_space", 2, 6, 1'b0);
    chk_brk("t5_aa_brk", 1'b0); chk_act("t5_aa_act1", 1, 1'b0); chk_act("t5_aa_act2", 2, 1'b0);
    send(8'hAA);
    chk_kp("t5_a_again", 1, 4, 1'b1); send(8'h1C);
    send(8'hF0);
    do_reset();
    chk_kp("t5_rst_clr_a", 1, 4, 1'b0); chk_brk("t5_rst_brk", 1'b0);
    drain();
    chk_kp("t5_return", 9, 4, 1'b1); chk_act("t5_act9", 9, 1'b1);
    chk_kp("t5_a_not_set", 1, 4, 1'b0); send(8'h5A);

    // Test 6: DIP links on row 0 and out-of-range columns
    for (int c = 2; c <= 9; c++) chk_kp($sformatf("t6_dip_c%0d", c), c, 0, dip[c - 2]);
    chk_kp("t6_row0_c0", 0, 0, 1'b0); chk_kp("t6_row0_c1", 1, 0, 1'b0);
    for (int c = 10; c <= 15; c++) begin
      chk_kp($sformatf("t6_kp_c%0d_r4", c), c, 4, 1'b0);
      chk_kp($sformatf("t6_kp_c%0d_r0", c), c, 0, 1'b0);
      chk_act($sformatf("t6_act_c%0d", c), c, 1'b0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
